hdr_cmd_scheduler: RTL and testbench

HDR_CMD_SCHEDULER -- requirements
Module: hdr_cmd_scheduler

---
 rtl/hdr_sched_pkg.sv | 26 ++
 rtl/hdr_rr_arb2.sv | 29 ++
 rtl/hdr_cmd_scheduler.sv | 126 ++++++++++++
 tb/tb_hdr_cmd_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/hdr_sched_pkg.sv
// ============================================================================
// Module      : hdr_sched_pkg
// Description : Shared types and constants for the HDR command scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hdr_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_CPL  = 2'd2,
    ST_ERR  = 2'd3
  } sched_state_t;

  // Descriptor packing: {TOC, CP, MODE[2:0]}
  localparam int         c_CMD_W       = 5;
  localparam int         c_TOC_BIT     = 4;
  localparam int         c_CP_BIT      = 3;
  localparam int         c_MODE_MSB    = 2;
  localparam logic [2:0] MODE_RESERVED = 3'b111;

endpackage

`default_nettype wire

// File: rtl/hdr_rr_arb2.sv
// ============================================================================
// Module      : hdr_rr_arb2
// Description : Two-input combinational round-robin arbiter, one-hot grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hdr_rr_arb2
  import hdr_sched_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_gnt
);

  // i_ptr names the requester favoured when both are pending.
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_ptr ? 2'b10 : 2'b01;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/hdr_cmd_scheduler.sv
// ============================================================================
// Module      : hdr_cmd_scheduler
// Description : Arbitrates two command queues onto one HDR engine with timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hdr_cmd_scheduler
  import hdr_sched_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               i_sys_clk,
  input  logic               i_sys_rst,
  input  logic [1:0]         i_req,
  input  logic [c_CMD_W-1:0] i_cmd0,
  input  logic [c_CMD_W-1:0] i_cmd1,
  input  logic               i_abort,
  input  logic               i_hdrengine_done,
  output logic [1:0]         o_gnt,
  output logic [1:0]         o_done,
  output logic [1:0]         o_err,
  output logic               o_hdrengine_en,
  output logic               o_TOC,
  output logic               o_CP,
  output logic [2:0]         o_MODE,
  output logic               o_busy
);

  localparam logic [15:0] c_CNT_LAST = 16'(TIMEOUT_CYC - 1);

  sched_state_t       r_state;
  logic               r_ptr;
  logic               r_owner;
  logic [15:0]        r_cnt;
  logic [1:0]         r_gnt;
  logic [1:0]         r_done;
  logic [1:0]         r_err;
  logic               r_en;
  logic               r_toc;
  logic               r_cp;
  logic [2:0]         r_mode;

  logic [1:0]         w_gnt;
  logic [c_CMD_W-1:0] w_cmd;
  logic [1:0]         w_owner_oh;

  hdr_rr_arb2 u_arb (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt)
  );

  assign w_cmd      = w_gnt[1] ? i_cmd1 : i_cmd0;
  assign w_owner_oh = r_owner ? 2'b10 : 2'b01;

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= 1'b0;
      r_owner <= 1'b0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_err   <= '0;
      r_en    <= 1'b0;
      r_toc   <= 1'b0;
      r_cp    <= 1'b0;
      r_mode  <= '0;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      r_err  <= '0;
      case (r_state)
        ST_IDLE: begin
          if (|i_req) begin
            r_owner <= w_gnt[1];
            r_gnt   <= w_gnt;
            r_toc   <= w_cmd[c_TOC_BIT];
            r_cp    <= w_cmd[c_CP_BIT];
            r_mode  <= w_cmd[c_MODE_MSB:0];
            r_cnt   <= '0;
            // A reserved mode is rejected before the engine ever sees it.
            if (w_cmd[c_MODE_MSB:0] == MODE_RESERVED) begin
              r_state <= ST_ERR;
              r_err   <= w_gnt;
            end else begin
              r_state <= ST_RUN;
              r_en    <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt + 16'd1;
          // Completion wins over a coincident abort or timeout.
          if (i_hdrengine_done) begin
            r_state <= ST_CPL;
            r_en    <= 1'b0;
            r_done  <= w_owner_oh;
          end else if (i_abort || (r_cnt == c_CNT_LAST)) begin
            r_state <= ST_ERR;
            r_en    <= 1'b0;
            r_err   <= w_owner_oh;
          end
        end
        ST_CPL, ST_ERR: begin
          r_ptr   <= ~r_owner;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_gnt          = r_gnt;
  assign o_done         = r_done;
  assign o_err          = r_err;
  assign o_hdrengine_en = r_en;
  assign o_TOC          = r_toc;
  assign o_CP           = r_cp;
  assign o_MODE         = r_mode;
  assign o_busy         = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_hdr_cmd_scheduler.sv
// ============================================================================
// Module      : tb_hdr_cmd_scheduler
// Description : Self-checking bench for hdr_cmd_scheduler with transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hdr_cmd_scheduler;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [4:0] cmd0, cmd1;
  logic       abort_i, done_i;
  logic [1:0] gnt, done_o, err_o;
  logic       en, toc, cp, busy;
  logic [2:0] mode;

  int tests = 0;
  int fails = 0;
  int exp_ptr = 0;

  always #5 clk = ~clk;

  hdr_cmd_scheduler #(.TIMEOUT_CYC(TO)) dut (
    .i_sys_clk        (clk),
    .i_sys_rst        (rst),
    .i_req            (req),
    .i_cmd0           (cmd0),
    .i_cmd1           (cmd1),
    .i_abort          (abort_i),
    .i_hdrengine_done (done_i),
    .o_gnt            (gnt),
    .o_done           (done_o),
    .o_err            (err_o),
    .o_hdrengine_en   (en),
    .o_TOC            (toc),
    .o_CP             (cp),
    .o_MODE           (mode),
    .o_busy           (busy)
  );

  // One command as a transaction: outcome is the earliest of done / abort /
  // timeout among RUN cycles 1..TO, with done winning a tie.
  task automatic do_cmd(input logic [1:0] r, input logic [4:0] c0, input logic [4:0] c1,
                        input int done_at, input int abort_at, input string tag);
    int w, td, ta, fin, en_cnt;
    bit is_done;
    logic [1:0] oh;
    logic [4:0] d;
    logic [7:0] exp, obs;
    w  = (r == 2'b01) ? 0 : (r == 2'b10) ? 1 : exp_ptr;
    oh = (w == 1) ? 2'b10 : 2'b01;
    d  = (w == 1) ? c1 : c0;
    req = r; cmd0 = c0; cmd1 = c1;
    @(posedge clk); #1;
    obs = {gnt, done_o, err_o, en, busy};
    exp = (d[2:0] == 3'b111) ? {oh, 2'b00, oh, 1'b0, 1'b1} : {oh, 2'b00, 2'b00, 1'b1, 1'b1};
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s grant_cycle got %b want %b", tag, obs, exp);
    end
    tests++;
    if ({toc, cp, mode} !== d) begin
      fails++;
      $display("FAIL %s descriptor got %b want %b", tag, {toc, cp, mode}, d);
    end
    cmd0 = 5'($urandom); cmd1 = 5'($urandom);
    if (d[2:0] != 3'b111) begin
      td  = (done_at >= 1 && done_at <= TO) ? done_at : TO + 100;
      ta  = (abort_at >= 1) ? abort_at : TO + 100;
      fin = TO;
      if (ta < fin) fin = ta;
      if (td <= fin) fin = td;
      is_done = (td == fin);
      en_cnt = en ? 1 : 0;
      for (int k = 1; k <= fin; k++) begin
        done_i  = (k == done_at);
        abort_i = (k == abort_at);
        @(posedge clk); #1;
        done_i = 1'b0; abort_i = 1'b0;
        obs = {gnt, done_o, err_o, en, busy};
        if (k < fin) begin
          exp = {2'b00, 2'b00, 2'b00, 1'b1, 1'b1};
          if (en) en_cnt++;
        end else if (is_done) begin
          exp = {2'b00, oh, 2'b00, 1'b0, 1'b1};
        end else begin
          exp = {2'b00, 2'b00, oh, 1'b0, 1'b1};
        end
        tests++;
        if (obs !== exp || {toc, cp, mode} !== d) begin
          fails++;
          $display("FAIL %s run_k%0d got %b/%b want %b/%b", tag, k, obs, {toc, cp, mode}, exp, d);
        end
      end
      tests++;
      if (en_cnt != fin) begin
        fails++;
        $display("FAIL %s en_high_cycles got %0d want %0d", tag, en_cnt, fin);
      end
    end
    @(posedge clk); #1;
    obs = {gnt, done_o, err_o, en, busy};
    tests++;
    if (obs !== 8'h00) begin
      fails++;
      $display("FAIL %s idle_after got %b want %b", tag, obs, 8'h00);
    end
    exp_ptr = 1 - w;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b01; cmd0 = 5'b11010; cmd1 = 5'b0;
    abort_i = 1'b0; done_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({gnt, done_o, err_o, en, busy, toc, cp, mode} !== 13'h0) begin
      fails++;
      $display("FAIL reset_state got %b want 0", {gnt, done_o, err_o, en, busy, toc, cp, mode});
    end
    rst = 1'b0; req = 2'b00;
    exp_ptr = 0;
  endtask

  task automatic test_basic();
    do_cmd(2'b01, 5'b10110, 5'b00000, 5, 0, "basic");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      do_cmd(2'b11, 5'b01010, 5'b10001, 3, 0, "b2b");
    req = 2'b00;
  endtask

  task automatic test_timeout();
    do_cmd(2'b10, 5'b00000, 5'b11011, 0, 0, "timeout");
    do_cmd(2'b01, 5'b00100, 5'b00000, TO, 0, "done_at_timeout");
    req = 2'b00;
  endtask

  task automatic test_reserved();
    do_cmd(2'b10, 5'b00001, 5'b10111, 0, 0, "reserved");
    req = 2'b00;
  endtask

  task automatic test_abort();
    do_cmd(2'b01, 5'b01001, 5'b00000, 3, 3, "abort_and_done");
    do_cmd(2'b01, 5'b01001, 5'b00000, 0, 2, "abort_only");
    do_cmd(2'b10, 5'b00000, 5'b00011, 1, 0, "done_first_cycle");
    req = 2'b00;
  endtask

  task automatic test_ignore_idle();
    req = 2'b00; done_i = 1'b1; abort_i = 1'b1;
    @(posedge clk); #1;
    done_i = 1'b0; abort_i = 1'b0;
    tests++;
    if ({gnt, done_o, err_o, en, busy} !== 8'h00) begin
      fails++;
      $display("FAIL ignore_idle got %b want 0", {gnt, done_o, err_o, en, busy});
    end
  endtask

  task automatic test_reset_mid_run();
    do_cmd(2'b01, 5'b00010, 5'b00000, 2, 0, "pre_reset");
    req = 2'b10; cmd1 = 5'b10101;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    tests++;
    if ({gnt, done_o, err_o, en, busy} !== 8'h00) begin
      fails++;
      $display("FAIL reset_async got %b want 0", {gnt, done_o, err_o, en, busy});
    end
    @(posedge clk); #1;
    tests++;
    if ({gnt, done_o, err_o, en, busy, toc, cp, mode} !== 13'h0) begin
      fails++;
      $display("FAIL reset_held got %b want 0", {gnt, done_o, err_o, en, busy, toc, cp, mode});
    end
    rst = 1'b0; req = 2'b00;
    exp_ptr = 0;
    do_cmd(2'b11, 5'b00101, 5'b00110, 2, 0, "post_reset");
    req = 2'b00;
  endtask

  task automatic test_random();
    logic [1:0] r;
    for (int i = 0; i < 30; i++) begin
      r = 2'($urandom_range(1, 3));
      do_cmd(r, 5'($urandom), 5'($urandom), int'($urandom_range(0, 10)),
             int'($urandom_range(0, 12)), "random");
      if ($urandom_range(0, 1) == 1) begin
        req = 2'b00;
        @(posedge clk); #1;
      end
    end
    req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_reserved();
    test_abort();
    test_ignore_idle();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
